aud_player: RTL and testbench

I2S audio transmitter: the playback-side counterpart of the recorder. It fetches 16-bit samples from SRAM and serialises each one MSB-first onto the codec DAC data line, framed by the codec-generated LRC. Each sample is sent on both the left and right channels. It sits between the top-level SRAM arbiter and the WM8731 DAC pin, under the top FSM's start/pause/stop control.

---
 rtl/aud_pkg.sv | 20 ++
 rtl/aud_ser.sv | 36 +++
 rtl/aud_player.sv | 154 +++++++++++++++
 tb/tb_aud_player.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared audio-path definitions used by the player, the recorder and the top FSM.
package aud_pkg;

    localparam int AUD_DATA_W = 16;
    localparam int AUD_ADDR_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_L  = 3'd1,
        ST_SHIFT_L = 3'd2,
        ST_WAIT_R  = 3'd3,
        ST_SHIFT_R = 3'd4,
        ST_PAUSED  = 3'd5
    } player_state_t;

    function automatic logic is_playing(input player_state_t s);
        return (s == ST_WAIT_L) || (s == ST_SHIFT_L) || (s == ST_WAIT_R) || (s == ST_SHIFT_R);
    endfunction

endpackage

// File: rtl/aud_ser.sv
// Parallel-load MSB-first shift register clocked on the falling BCLK edge.
// nxt_bit is the bit that becomes the MSB on the next shift; done marks W bits driven.
module aud_ser #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         nxt_bit,
    output logic         done
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  q;
    logic [CW-1:0] cnt;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= din;
            cnt <= '0;
        end else if (shift) begin
            q   <= {q[W-2:0], q[W-1]};
            cnt <= cnt + 1'b1;
        end
    end

    assign nxt_bit = q[W-2];
    assign done    = (cnt == CW'(W - 1));

endmodule

// File: rtl/aud_player.sv
// I2S playback: fetches one SRAM sample per frame and sends it MSB-first on both
// channels, aligned to the codec LRC. All state advances on the falling BCLK edge.
module aud_player
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter int ADDR_W = AUD_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_aud_dacdat,
    output logic              o_done,
    output logic              o_playing,
    output player_state_t     o_state
);

    player_state_t     state, state_d;
    logic              lrc_q;
    logic [ADDR_W-1:0] address, addr_d;
    logic              dacdat, dac_d;
    logic              done, done_d;
    logic              pause_pending, pend_d;
    logic [DATA_W-1:0] hold, hold_d;

    logic              ser_load, ser_shift, ser_nxt, ser_done;
    logic [DATA_W-1:0] ser_din;
    logic              lfall, lrise;

    assign lfall = lrc_q & ~i_lrc;
    assign lrise = ~lrc_q & i_lrc;

    aud_ser #(.W(DATA_W)) u_ser (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .load   (ser_load),
        .shift  (ser_shift),
        .din    (ser_din),
        .nxt_bit(ser_nxt),
        .done   (ser_done)
    );

    // Pulse controls are single-cycle and evaluated every edge with stop > pause > start.
    always_comb begin
        state_d   = state;
        addr_d    = address;
        dac_d     = dacdat;
        done_d    = 1'b0;
        pend_d    = pause_pending;
        hold_d    = hold;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_din   = hold;
        if (i_stop) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            dac_d   = 1'b0;
            pend_d  = 1'b0;
        end else begin
            if (is_playing(state) && i_pause) begin
                pend_d = 1'b1;
            end
            case (state)
                ST_IDLE, ST_PAUSED: begin
                    if (i_start && !i_pause) begin
                        state_d = ST_WAIT_L;
                        pend_d  = 1'b0;
                    end
                end
                ST_WAIT_L: begin
                    if (lfall) begin
                        ser_load = 1'b1;
                        ser_din  = i_sram_data;
                        hold_d   = i_sram_data;
                        dac_d    = i_sram_data[DATA_W-1];
                        state_d  = ST_SHIFT_L;
                    end
                end
                ST_SHIFT_L: begin
                    if (ser_done) begin
                        dac_d   = 1'b0;
                        state_d = ST_WAIT_R;
                    end else begin
                        ser_shift = 1'b1;
                        dac_d     = ser_nxt;
                    end
                end
                ST_WAIT_R: begin
                    // The right channel replays the held copy; SRAM is free to move on.
                    if (lrise) begin
                        ser_load = 1'b1;
                        dac_d    = hold[DATA_W-1];
                        state_d  = ST_SHIFT_R;
                    end
                end
                ST_SHIFT_R: begin
                    if (ser_done) begin
                        dac_d = 1'b0;
                        if (address == i_end_addr) begin
                            done_d  = 1'b1;
                            addr_d  = '0;
                            pend_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            addr_d  = address + ADDR_W'(1);
                            state_d = (pause_pending || i_pause) ? ST_PAUSED : ST_WAIT_L;
                        end
                    end else begin
                        ser_shift = 1'b1;
                        dac_d     = ser_nxt;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    dac_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            lrc_q         <= 1'b0;
            address       <= '0;
            dacdat        <= 1'b0;
            done          <= 1'b0;
            pause_pending <= 1'b0;
            hold          <= '0;
        end else begin
            state         <= state_d;
            lrc_q         <= i_lrc;
            address       <= addr_d;
            dacdat        <= dac_d;
            done          <= done_d;
            pause_pending <= pend_d;
            hold          <= hold_d;
        end
    end

    assign o_address    = address;
    assign o_aud_dacdat = dacdat;
    assign o_done       = done;
    assign o_playing    = is_playing(state);
    assign o_state      = state;

endmodule

// File: tb/tb_aud_player.sv
// Bench for aud_player: expected DAC bit stream, address, done and playing flags
// come from a frame-level model of the I2S player driven by a free-running LRC.
module tb_aud_player;
    import aud_pkg::*;

    localparam int DW   = 16;
    localparam int AW   = 20;
    localparam int HALF = 24;
    localparam int M_IDLE = 0, M_WL = 1, M_WR = 2, M_BR = 3, M_PAUSED = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_lrc = 1'b1;
    logic          i_start = 1'b0;
    logic          i_pause = 1'b0;
    logic          i_stop = 1'b0;
    logic [AW-1:0] i_end_addr = 4;
    logic [DW-1:0] i_sram_data = '0;
    logic [AW-1:0] o_address;
    logic          o_aud_dacdat;
    logic          o_done;
    logic          o_playing;
    player_state_t o_state;

    aud_player dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lrc       (i_lrc),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_stop      (i_stop),
        .i_end_addr  (i_end_addr),
        .i_sram_data (i_sram_data),
        .o_address   (o_address),
        .o_aud_dacdat(o_aud_dacdat),
        .o_done      (o_done),
        .o_playing   (o_playing),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] sram [0:15];
    logic [0:0]    exp_q[$];
    logic [AW-1:0] m_addr = '0;
    int            m_st = M_IDLE;
    logic          m_pause = 1'b0;
    logic          ev_pending = 1'b0;
    int            ev_step = 0;
    int            cyc = 0;
    int            lrc_cnt = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        for (int b = DW - 1; b >= 0; b--) exp_q.push_back(w[b]);
    endtask

    task automatic model_reset();
        m_st = M_IDLE;
        m_addr = '0;
        m_pause = 1'b0;
        exp_q.delete();
        ev_pending = 1'b0;
    endtask

    task automatic lrc_edge();
        if (!i_lrc && m_st == M_WL) begin
            push_word(sram[m_addr[3:0]]);
            m_st = M_WR;
        end else if (i_lrc && m_st == M_WR) begin
            push_word(sram[m_addr[3:0]]);
            m_st = M_BR;
            ev_pending = 1'b1;
            ev_step = cyc + DW + 1;
        end
    endtask

    // One BCLK: sample outputs at the rising edge, then drive the next inputs.
    task automatic step();
        logic exp_bit;
        logic exp_done;
        @(posedge i_clk);
        cyc++;
        exp_done = 1'b0;
        if (ev_pending && cyc == ev_step) begin
            ev_pending = 1'b0;
            if (m_addr == i_end_addr) begin
                exp_done = 1'b1;
                m_addr = '0;
                m_st = M_IDLE;
                m_pause = 1'b0;
            end else begin
                m_addr = m_addr + 1'b1;
                m_st = m_pause ? M_PAUSED : M_WL;
            end
        end
        exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        chk("dacdat", 32'(o_aud_dacdat), 32'(exp_bit));
        chk("address", 32'(o_address), 32'(m_addr));
        chk("done", 32'(o_done), 32'(exp_done));
        chk("playing", 32'(o_playing), 32'(m_st inside {M_WL, M_WR, M_BR}));
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop = 1'b0;
        i_sram_data = (m_st == M_WL) ? sram[m_addr[3:0]] : DW'($urandom);
        lrc_cnt++;
        if (lrc_cnt == HALF) begin
            lrc_cnt = 0;
            i_lrc = ~i_lrc;
            lrc_edge();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align();
        int i = 0;
        while ((lrc_cnt < 3 || lrc_cnt > HALF - 4) && i < 2 * HALF) begin
            step();
            i++;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        if (m_st == M_IDLE || m_st == M_PAUSED) begin
            m_st = M_WL;
            m_pause = 1'b0;
        end
    endtask

    task automatic pulse_pause();
        i_pause = 1'b1;
        if (m_st inside {M_WL, M_WR, M_BR}) m_pause = 1'b1;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        model_reset();
    endtask

    task automatic wait_point(input string tag, input int addr, input int st, input int qsz);
        int i = 0;
        while (i < 4000 && !(m_addr == AW'(addr) && m_st == st && exp_q.size() == qsz)) begin
            step();
            i++;
        end
        chk(tag, 32'(m_addr == AW'(addr) && m_st == st && exp_q.size() == qsz), 32'd1);
    endtask

    task automatic wait_state(input string tag, input int st);
        int i = 0;
        while (i < 6000 && m_st != st) begin
            step();
            i++;
        end
        chk(tag, 32'(m_st == st), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pz;
        int k;
        int paused_for;
        for (int i = 0; i < 16; i++) sram[i] = DW'($urandom);
        sram[0] = 16'hF2CF;
        sram[1] = 16'hF64F;
        sram[2] = 16'h83C1;
        sram[3] = 16'h9C58;
        sram[4] = 16'h6A4C;

        // reset values
        run(3);
        chk("reset_state", 32'(o_state), 32'(ST_IDLE));
        i_rst_n = 1'b1;
        run(HALF);

        // full five-word playback
        align();
        pulse_start();
        wait_state("play5_end", M_IDLE);
        run(4);

        // pause during bit 5 of the left channel of word 1
        align();
        pulse_start();
        wait_point("pause_point", 1, M_WR, DW - 5);
        pulse_pause();
        wait_state("pause_reached", M_PAUSED);
        run(6 * HALF);
        chk("paused_state", 32'(o_state), 32'(ST_PAUSED));
        chk("paused_addr", 32'(o_address), 32'd2);
        align();
        pulse_start();

        // stop during bit 8 of word 2
        wait_point("stop_point", 2, M_WR, DW - 8);
        pulse_stop();
        step();
        chk("stop_state", 32'(o_state), 32'(ST_IDLE));
        run(4 * HALF);

        // stop and start together while idle
        align();
        pulse_stop();
        i_start = 1'b1;
        run(3 * HALF);
        chk("stop_start_idle", 32'(o_state), 32'(ST_IDLE));

        // asynchronous reset in the middle of the right channel
        align();
        pulse_start();
        wait_point("reset_point", 0, M_BR, 7);
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_dacdat", 32'(o_aud_dacdat), 32'd0);
        chk("rst_address", 32'(o_address), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_playing", 32'(o_playing), 32'd0);
        chk("rst_state", 32'(o_state), 32'(ST_IDLE));
        run(5);
        i_rst_n = 1'b1;
        run(HALF);
        align();
        pulse_start();
        wait_state("replay_end", M_IDLE);

        // randomized playbacks with random pause/resume points
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) sram[i] = DW'($urandom);
            i_end_addr = AW'($urandom_range(1, 5));
            run(HALF);
            align();
            pulse_start();
            pz = $urandom_range(10, 150);
            k = 0;
            paused_for = 0;
            while (m_st != M_IDLE && k < 3000) begin
                step();
                k++;
                if (k == pz) pulse_pause();
                if (m_st == M_PAUSED) begin
                    paused_for++;
                    if (paused_for > 30 && lrc_cnt >= 3 && lrc_cnt <= HALF - 4) begin
                        pulse_start();
                        paused_for = 0;
                    end
                end
            end
            chk("rand_finish", 32'(m_st == M_IDLE), 32'd1);
            run(4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
